// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared types, constants and word formatter for the commit trace buffer
package commit_trace_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
    } commit_rec_t;

    localparam int TRACE_WORDS = 6;
    localparam int FLG_HALT    = 31;
    localparam int FLG_REG_WE  = 30;
    localparam int FLG_DMEM_WE = 29;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_t;

    function automatic logic [31:0] trace_word(commit_rec_t r, logic [2:0] idx);
        logic [31:0] flags;
        flags              = '0;
        flags[FLG_HALT]    = r.halt;
        flags[FLG_REG_WE]  = r.reg_we;
        flags[FLG_DMEM_WE] = r.dmem_we;
        flags[4:0]         = r.reg_wa;
        case (idx)
            3'd0:    return r.pc;
            3'd1:    return r.inst;
            3'd2:    return flags;
            3'd3:    return r.reg_wd;
            3'd4:    return r.dmem_wa;
            default: return r.dmem_wd;
        endcase
    endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// rtl/commit_trace_buf_if.sv - commit port and trace word stream bundle
interface commit_trace_buf_if;
    logic        commit;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_halt;
    logic        commit_reg_we;
    logic [4:0]  commit_reg_wa;
    logic [31:0] commit_reg_wd;
    logic        commit_dmem_we;
    logic [31:0] commit_dmem_wa;
    logic [31:0] commit_dmem_wd;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    // master: CPU commit side plus trace sink; slave: the trace buffer
    modport master (
        output commit, commit_pc, commit_inst, commit_halt,
        output commit_reg_we, commit_reg_wa, commit_reg_wd,
        output commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
        output out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  commit, commit_pc, commit_inst, commit_halt,
        input  commit_reg_we, commit_reg_wa, commit_reg_wd,
        input  commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
        input  out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO of commit records with occupancy count
module trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  commit_rec_t              wdata,
    input  logic                     pop,
    output commit_rec_t              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    commit_rec_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/commit_trace_buf.sv
// rtl/commit_trace_buf.sv - buffers CPU commit records and replays each as a six-word trace stream
// Optional: COMMIT_TRACE_FILTER_EN keeps only records that write a register, write memory or halt.
module commit_trace_buf
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AFULL = 2
) (
    input  logic                clk,
    input  logic                rst,
    commit_trace_buf_if.slave   tif,
    output logic                stall_hint,
    output logic                overflow,
    output logic [15:0]         drop_cnt,
    output logic                halted
);
    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(TRACE_WORDS - 1);

    commit_rec_t   in_rec;
    commit_rec_t   head_rec;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wants;
    logic          push;
    logic          pop;
    logic          drop;

    ser_state_t    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          halted_q, halted_d;

    always_comb begin
        in_rec         = '0;
        in_rec.pc      = tif.commit_pc;
        in_rec.inst    = tif.commit_inst;
        in_rec.halt    = tif.commit_halt;
        in_rec.reg_we  = tif.commit_reg_we;
        in_rec.reg_wa  = tif.commit_reg_wa;
        in_rec.reg_wd  = tif.commit_reg_wd;
        in_rec.dmem_we = tif.commit_dmem_we;
        in_rec.dmem_wa = tif.commit_dmem_wa;
        in_rec.dmem_wd = tif.commit_dmem_wd;
    end

`ifdef COMMIT_TRACE_FILTER_EN
    assign wants = tif.commit && !halted_q &&
                   (tif.commit_reg_we || tif.commit_dmem_we || tif.commit_halt);
`else
    assign wants = tif.commit && !halted_q;
`endif

    // A record leaving on this edge frees its slot for a same-edge commit.
    assign pop  = (state_q == ST_SEND) && out_valid_q && tif.out_ready && (idx_q == LAST_IDX);
    assign push = wants && (!full || pop);
    assign drop = wants && full && !pop;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_rec),
        .pop   (pop),
        .rdata (head_rec),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d     = ST_SEND;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (out_valid_q && tif.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        out_last_d = 1'b0;
                        // Stay in SEND if a record remains after this pop, counting a same-edge push.
                        if (count > CW'(1) || push) begin
                            state_d = ST_SEND;
                        end else begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        out_last_d = ((idx_q + 3'd1) == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        halted_d = halted_q | (push && tif.commit_halt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            halted_q   <= halted_d;
        end
    end

    // Head record and index are both registered, so the word holds steady while stalled.
    assign tif.out_data  = out_valid_q ? trace_word(head_rec, idx_q) : 32'h0;
    assign tif.out_valid = out_valid_q;
    assign tif.out_last  = out_last_q;
    assign stall_hint    = ((DEPTH - int'(count)) <= AFULL);
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_commit_trace_buf.sv
// tb/tb_commit_trace_buf.sv - self-checking bench for commit_trace_buf
module tb_commit_trace_buf;
    import commit_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 2;
`ifdef COMMIT_TRACE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_hint;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        halted;

    commit_trace_buf_if tif();

    commit_trace_buf #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk        (clk),
        .rst        (rst),
        .tif        (tif),
        .stall_hint (stall_hint),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        commit_rec_t rec;
        logic        accept;
        logic [31:0] flags;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic commit_rec_t mk(logic [31:0] pc, logic [31:0] inst, logic halt,
                                       logic rwe, logic [4:0] wa, logic [31:0] wd,
                                       logic dwe, logic [31:0] da, logic [31:0] dd);
        commit_rec_t r;
        r.pc = pc; r.inst = inst; r.halt = halt;
        r.reg_we = rwe; r.reg_wa = wa; r.reg_wd = wd;
        r.dmem_we = dwe; r.dmem_wa = da; r.dmem_wd = dd;
        return r;
    endfunction

    task automatic set_rec(commit_rec_t r);
        tif.commit         = 1'b1;
        tif.commit_pc      = r.pc;
        tif.commit_inst    = r.inst;
        tif.commit_halt    = r.halt;
        tif.commit_reg_we  = r.reg_we;
        tif.commit_reg_wa  = r.reg_wa;
        tif.commit_reg_wd  = r.reg_wd;
        tif.commit_dmem_we = r.dmem_we;
        tif.commit_dmem_wa = r.dmem_wa;
        tif.commit_dmem_wd = r.dmem_wd;
    endtask

    task automatic expect_rec(commit_rec_t r, logic [31:0] flags);
        sb.push_back('{data: r.pc,      last: 1'b0});
        sb.push_back('{data: r.inst,    last: 1'b0});
        sb.push_back('{data: flags,     last: 1'b0});
        sb.push_back('{data: r.reg_wd,  last: 1'b0});
        sb.push_back('{data: r.dmem_wa, last: 1'b0});
        sb.push_back('{data: r.dmem_wd, last: 1'b1});
    endtask

    task automatic drain(string name, int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words pending, expected 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        tif.commit    = 1'b0;
        tif.out_ready = 1'b0;
        rst           = 1'b0;
        sb.delete();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Scoreboard monitor: samples on the falling edge, checks hold stability and word order.
    initial begin
        logic        hold;
        logic [31:0] hd;
        logic        hl;
        exp_t        e;
        hold = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(tif.out_valid), 32'd1);
                    chk("hold_data", tif.out_data, hd);
                    chk("hold_last", 32'(tif.out_last), 32'(hl));
                end
                hold = tif.out_valid && !tif.out_ready;
                hd   = tif.out_data;
                hl   = tif.out_last;
                if (tif.out_valid && tif.out_ready) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected none", tif.out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", tif.out_data, e.data);
                        chk("word_last", 32'(tif.out_last), 32'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        vec_t        tbl[5];
        commit_rec_t r;
        int          xf0;

        tif.commit = 1'b0;
        tif.out_ready = 1'b0;
        set_rec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tif.commit = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(tif.out_valid), 0);
        chk("rst_out_data", tif.out_data, 0);
        chk("rst_out_last", 32'(tif.out_last), 0);
        chk("rst_stall_hint", 32'(stall_hint), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        rst = 1'b1;
        step();

        // Single commit: latency and six consecutive words
        tif.out_ready = 1'b1;
        r = mk(32'h3000, 32'h0010_0093, 0, 1, 5'd1, 32'd1, 0, 0, 0);
        set_rec(r);
        expect_rec(r, 32'h4000_0001);
        step();
        tif.commit = 1'b0;
        chk("lat_not_yet", 32'(tif.out_valid), 0);
        step();
        chk("lat_valid", 32'(tif.out_valid), 1);
        chk("lat_w0", tif.out_data, 32'h3000);
        xf0 = xfers;
        repeat (6) step();
        chk("single_xfers", 32'(xfers - xf0), 6);
        chk("single_idle", 32'(tif.out_valid), 0);
        chk("single_sb_empty", 32'(sb.size()), 0);

        // Table: branch then store first, exercising the filter when enabled
        tbl[0] = '{mk(32'h100, 32'h0000_0063, 0, 0, 5'd0, 0, 0, 0, 0), !FILT, 32'h0000_0000};
        tbl[1] = '{mk(32'h104, 32'h0011_2023, 0, 0, 5'd0, 0, 1, 32'h2000, 32'hDEAD_BEEF), 1'b1, 32'h2000_0000};
        tbl[2] = '{mk(32'h108, 32'h1234_5678, 0, 1, 5'd31, 32'h1234, 1, 32'h2004, 32'h55AA), 1'b1, 32'h6000_001F};
        tbl[3] = '{mk(32'h10C, 32'hCAFE_0001, 0, 0, 5'd5, 32'h77, 0, 32'h9, 32'h8), !FILT, 32'h0000_0005};
        tbl[4] = '{mk(32'h110, 32'hCAFE_0002, 0, 1, 5'd16, 32'hFFFF_FFFF, 0, 0, 0), 1'b1, 32'h4000_0010};
        for (int i = 0; i < 5; i++) begin
            set_rec(tbl[i].rec);
            if (tbl[i].accept) expect_rec(tbl[i].rec, tbl[i].flags);
            step();
        end
        tif.commit = 1'b0;
        drain("table_drain", 100);
        chk("table_drop_cnt", 32'(drop_cnt), 0);

        // out_ready toggling every cycle
        do_reset();
        r = mk(32'h200, 32'hABCD_0001, 0, 1, 5'd3, 32'h33, 1, 32'h44, 32'h55);
        set_rec(r);
        expect_rec(r, 32'h6000_0003);
        step();
        tif.commit = 1'b0;
        xf0 = xfers;
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            tif.out_ready = ~tif.out_ready;
            step();
        end
        chk("toggle_xfers", 32'(xfers - xf0), 6);
        chk("toggle_sb_empty", 32'(sb.size()), 0);
        tif.out_ready = 1'b0;

        // 20 back-to-back commits into a stalled sink
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            r = mk(32'h1000 + 32'(4 * k), 32'h13 + 32'(k), 0, 1, 5'(k), 32'(k), 0, 0, 0);
            set_rec(r);
            if (k <= DEPTH) expect_rec(r, 32'h4000_0000 | 32'(k));
            step();
            chk("burst_stall_hint", 32'(stall_hint), 32'(k >= 14));
            chk("burst_drop_cnt", 32'(drop_cnt), 32'(k > DEPTH ? k - DEPTH : 0));
            chk("burst_overflow", 32'(overflow), 32'(k > DEPTH));
        end
        tif.commit = 1'b0;
        tif.out_ready = 1'b1;
        xf0 = xfers;
        drain("burst_drain", 200);
        chk("burst_xfers", 32'(xfers - xf0), 96);

        // Full FIFO with a commit on the edge W5 is accepted
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            r = mk(32'h5000 + 32'(k), 32'h7000 + 32'(k), 0, 1, 5'(k), 32'(k * 3), 0, 0, 0);
            set_rec(r);
            expect_rec(r, 32'h4000_0000 | 32'(k));
            step();
        end
        tif.commit = 1'b0;
        chk("full_stall_hint", 32'(stall_hint), 1);
        tif.out_ready = 1'b1;
        repeat (5) step();
        r = mk(32'h5100, 32'h7100, 0, 1, 5'd9, 32'h99, 0, 0, 0);
        set_rec(r);
        expect_rec(r, 32'h4000_0009);
        step();
        tif.commit = 1'b0;
        chk("fullpop_drop_cnt", 32'(drop_cnt), 0);
        chk("fullpop_overflow", 32'(overflow), 0);
        chk("fullpop_count_same", 32'(stall_hint), 1);
        drain("fullpop_drain", 200);

        // Halt captured, later commits ignored
        do_reset();
        tif.out_ready = 1'b1;
        r = mk(32'h4000, 32'h0000_0073, 1, 0, 5'd0, 0, 0, 0, 0);
        set_rec(r);
        expect_rec(r, 32'h8000_0000);
        step();
        for (int k = 0; k < 3; k++) begin
            set_rec(mk(32'h4004 + 32'(4 * k), 32'h13, 0, 1, 5'd2, 32'(k), 0, 0, 0));
            step();
        end
        tif.commit = 1'b0;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_drop_cnt", 32'(drop_cnt), 0);
        chk("halt_overflow", 32'(overflow), 0);
        drain("halt_drain", 50);
        repeat (10) step();
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_quiet", 32'(tif.out_valid), 0);

        // Reset asserted mid-record abandons the stream
        do_reset();
        chk("rst_clears_halted", 32'(halted), 0);
        tif.out_ready = 1'b1;
        r = mk(32'h6000, 32'h6001, 0, 1, 5'd7, 32'h6002, 1, 32'h6003, 32'h6004);
        set_rec(r);
        expect_rec(r, 32'h6000_0007);
        step();
        tif.commit = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(tif.out_valid), 0);
        chk("midrst_data", tif.out_data, 0);
        chk("midrst_last", 32'(tif.out_last), 0);
        chk("midrst_stall", 32'(stall_hint), 0);
        sb.delete();
        step();
        rst = 1'b1;
        repeat (10) step();
        chk("midrst_quiet", 32'(tif.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
